// File: rtl/ssm_pkg.sv
// Shared constants and segment-select helper for the dynamic-segment multiplier.
package ssm_pkg;

  localparam int unsigned DefN    = 23;
  localparam int unsigned DefM    = 18;
  localparam int unsigned DefCntW = 16;
  localparam int unsigned SegMaxW = 64;

  // Returns the M-bit segment of an n-bit operand (zero-extended to SegMaxW).
  // High segment carries a sticky OR of the dropped low bits in its LSB.
  function automatic logic [SegMaxW-1:0] seg_select(input logic [SegMaxW-1:0] x,
                                                    input int unsigned n,
                                                    input int unsigned m,
                                                    output logic alfa,
                                                    output logic [7:0] sh);
    logic [SegMaxW-1:0] mask;
    logic [SegMaxW-1:0] seg;
    logic               lo_or;
    alfa  = 1'b0;
    lo_or = 1'b0;
    mask  = '1;
    mask  = mask >> (SegMaxW - m);
    for (int unsigned i = 0; i < SegMaxW; i++) begin
      if (i >= m && i < n) alfa = alfa | x[i];
      if (i < n - m) lo_or = lo_or | x[i];
    end
    if (alfa) begin
      seg    = (x >> (n - m)) & mask;
      seg[0] = seg[0] | lo_or;
      sh     = 8'(n - m);
    end else begin
      seg = x & mask;
      sh  = 8'd0;
    end
    return seg;
  endfunction

endpackage

// File: rtl/ssm_seg_sel.sv
// Per-operand segment extractor: leading-segment detection plus sticky compensation.
module ssm_seg_sel
  import ssm_pkg::*;
#(
  parameter int unsigned N   = DefN,
  parameter int unsigned M   = DefM,
  parameter int unsigned ShW = $clog2(N - M + 1)
) (
  input  logic [N-1:0]   x_i,
  output logic           alfa_o,
  output logic [M-1:0]   seg_o,
  output logic [ShW-1:0] sh_o
);

  logic [SegMaxW-1:0] seg_full;
  logic [7:0]         sh_full;
  logic               alfa;
  logic               unused_bits;

  always_comb begin
    alfa     = 1'b0;
    sh_full  = 8'd0;
    seg_full = seg_select(SegMaxW'(x_i), N, M, alfa, sh_full);
  end

  assign alfa_o      = alfa;
  assign seg_o       = seg_full[M-1:0];
  assign sh_o        = sh_full[ShW-1:0];
  assign unused_bits = ^{seg_full[SegMaxW-1:M], sh_full[7:ShW]};

endmodule

// File: rtl/ssm_mult_pipe.sv
// Three-stage dynamic-segment approximate multiplier with exact bypass,
// valid/ready back-pressure and a saturating approximate-result counter.
module ssm_mult_pipe
  import ssm_pkg::*;
#(
  parameter int unsigned N     = DefN,
  parameter int unsigned M     = DefM,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_p,
  output logic             out_approx,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] approx_cnt
);

  localparam int unsigned ShW    = $clog2(N - M + 1);
  localparam int unsigned ShSumW = $clog2(2 * (N - M) + 1);

  logic en;

  // Segment extraction (combinational, registered in S1)
  logic           alfa_a, alfa_b;
  logic [M-1:0]   seg_a, seg_b;
  logic [ShW-1:0] sh_a, sh_b;

  ssm_seg_sel #(.N(N), .M(M), .ShW(ShW)) u_sel_a (
    .x_i   (in_a),
    .alfa_o(alfa_a),
    .seg_o (seg_a),
    .sh_o  (sh_a)
  );

  ssm_seg_sel #(.N(N), .M(M), .ShW(ShW)) u_sel_b (
    .x_i   (in_b),
    .alfa_o(alfa_b),
    .seg_o (seg_b),
    .sh_o  (sh_b)
  );

  // Stage registers
  logic           s1_valid_q, s1_exact_q, s1_alfa_a_q, s1_alfa_b_q;
  logic [N-1:0]   s1_a_q, s1_b_q;
  logic [M-1:0]   s1_seg_a_q, s1_seg_b_q;
  logic [ShW-1:0] s1_sh_a_q, s1_sh_b_q;

  logic              s2_valid_q, s2_approx_q;
  logic [2*N-1:0]    s2_prod_q;
  logic [ShSumW-1:0] s2_sh_q;

  logic             s3_valid_q, s3_approx_q;
  logic [2*N-1:0]   s3_p_q;
  logic [CNT_W-1:0] cnt_q;

  // Next-state values
  logic [2*M-1:0]    seg_prod;
  logic [2*N-1:0]    exact_prod;
  logic [2*N-1:0]    s2_prod_d;
  logic [ShSumW-1:0] s2_sh_d;
  logic              s2_approx_d;
  logic [2*N-1:0]    s3_p_d;
  logic [CNT_W-1:0]  cnt_d;

  assign en       = !s3_valid_q || out_ready;
  assign in_ready = en;

  always_comb begin
    seg_prod    = (2*M)'(s1_seg_a_q) * (2*M)'(s1_seg_b_q);
    exact_prod  = (2*N)'(s1_a_q) * (2*N)'(s1_b_q);
    s2_prod_d   = (2*N)'(seg_prod);
    s2_sh_d     = ShSumW'(s1_sh_a_q) + ShSumW'(s1_sh_b_q);
    s2_approx_d = !s1_exact_q && (s1_alfa_a_q || s1_alfa_b_q);
    // Exact mode rides the same S3 shifter with a zero shift
    if (s1_exact_q) begin
      s2_prod_d = exact_prod;
      s2_sh_d   = '0;
    end
    s3_p_d = s2_prod_q << s2_sh_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (s3_valid_q && out_ready && s3_approx_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= 1'b0;
      s1_alfa_a_q <= 1'b0;
      s1_alfa_b_q <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_seg_a_q  <= '0;
      s1_seg_b_q  <= '0;
      s1_sh_a_q   <= '0;
      s1_sh_b_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_approx_q <= 1'b0;
      s2_prod_q   <= '0;
      s2_sh_q     <= '0;
      s3_valid_q  <= 1'b0;
      s3_approx_q <= 1'b0;
      s3_p_q      <= '0;
    end else if (en) begin
      s1_valid_q  <= in_valid;
      s1_exact_q  <= in_exact;
      s1_alfa_a_q <= alfa_a;
      s1_alfa_b_q <= alfa_b;
      s1_a_q      <= in_a;
      s1_b_q      <= in_b;
      s1_seg_a_q  <= seg_a;
      s1_seg_b_q  <= seg_b;
      s1_sh_a_q   <= sh_a;
      s1_sh_b_q   <= sh_b;
      s2_valid_q  <= s1_valid_q;
      s2_approx_q <= s2_approx_d;
      s2_prod_q   <= s2_prod_d;
      s2_sh_q     <= s2_sh_d;
      s3_valid_q  <= s2_valid_q;
      s3_approx_q <= s2_approx_q;
      s3_p_q      <= s3_p_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = s3_valid_q;
  assign out_p      = s3_p_q;
  assign out_approx = s3_approx_q;
  assign approx_cnt = cnt_q;

endmodule

// File: tb/tb_ssm_mult_pipe.sv
// Directed self-checking bench for ssm_mult_pipe (N=23, M=18, CNT_W=16).
module tb_ssm_mult_pipe;

  localparam int unsigned N = 23;
  localparam int unsigned M = 18;
  localparam int unsigned CntW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready, in_exact;
  logic [N-1:0]    in_a, in_b;
  logic            out_valid, out_ready, out_approx;
  logic [2*N-1:0]  out_p;
  logic            cnt_clr;
  logic [CntW-1:0] approx_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssm_mult_pipe #(.N(N), .M(M), .CNT_W(CntW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_exact  (in_exact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_approx(out_approx),
    .cnt_clr   (cnt_clr),
    .approx_cnt(approx_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction through an empty pipe with out_ready=1; returns result and latency.
  task automatic run_one(input logic [N-1:0] a, input logic [N-1:0] b, input logic exact,
                         output logic [63:0] p, output logic approx, output int lat);
    in_a      = a;
    in_b      = b;
    in_exact  = exact;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    lat      = 1;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    p      = 64'(out_p);
    approx = out_approx;
    tick();
  endtask

  logic [63:0] p, held_p;
  logic        approx, held, fire_in;
  int          lat, sent, recv, cyc, seen;
  logic [63:0] exp_q [10];

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_exact  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_p", 64'(out_p), 64'd0);
    check("rst_out_approx", 64'(out_approx), 64'd0);
    check("rst_cnt", 64'(approx_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Small operands: exact representation even in approximate mode
    run_one(23'd1000, 23'd2000, 1'b0, p, approx, lat);
    check("small_p", p, 64'd2000000);
    check("small_approx", 64'(approx), 64'd0);
    check("small_latency", 64'(lat), 64'd3);

    run_one(23'h400000, 23'd3, 1'b0, p, approx, lat);
    check("large_p", p, 64'd12582912);
    check("large_approx", 64'(approx), 64'd1);
    check("large_cnt", 64'(approx_cnt), 64'd1);

    run_one(23'h400001, 23'd3, 1'b0, p, approx, lat);
    check("sticky_p", p, 64'd12583008);
    run_one(23'h400001, 23'd3, 1'b1, p, approx, lat);
    check("exact_p", p, 64'd12582915);
    check("exact_approx", 64'(approx), 64'd0);
    check("exact_latency", 64'(lat), 64'd3);

    run_one(23'h400000, 23'h400000, 1'b0, p, approx, lat);
    check("both_pow_p", p, 64'd17592186044416);
    run_one(23'h7FFFFF, 23'h7FFFFF, 1'b0, p, approx, lat);
    check("both_max_p", p, 64'd70368207307776);
    check("cnt_after_dir", 64'(approx_cnt), 64'd4);

    // Streaming with out_ready pattern 1,0,0,1
    for (int i = 0; i < 10; i++) exp_q[i] = 64'((i * 1000 + 7) * (i + 3));
    sent = 0;
    recv = 0;
    cyc  = 0;
    held = 1'b0;
    held_p = '0;
    in_exact = 1'b0;
    while (recv < 10 && cyc < 200) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 10);
      in_a      = N'(sent * 1000 + 7);
      in_b      = N'(sent + 3);
      #1;
      if (out_valid) check("stream_in_ready", 64'(in_ready), 64'(out_ready));
      if (held && out_valid) check("stream_stable", 64'(out_p), held_p);
      fire_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check("stream_p", 64'(out_p), exp_q[recv]);
        recv++;
      end
      held   = out_valid && !out_ready;
      held_p = 64'(out_p);
      @(posedge clk);
      #1;
      if (fire_in) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_recv", 64'(recv), 64'd10);
    check("stream_sent", 64'(sent), 64'd10);
    repeat (5) tick();
    check("stream_no_extra", 64'(out_valid), 64'd0);

    // Counter fill to 0xFFFE, then saturate
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cnt_clr_idle", 64'(approx_cnt), 64'd0);
    in_a     = 23'h400000;
    in_b     = 23'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("cnt_fffe", 64'(approx_cnt), 64'hFFFE);
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("cnt_sat", 64'(approx_cnt), 64'hFFFF);

    // cnt_clr wins over a coincident approximate transfer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("clr_wait_valid", 64'(out_valid), 64'd1);
    check("clr_pending_approx", 64'(out_approx), 64'd1);
    cnt_clr   = 1'b1;
    out_ready = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_with_xfer", 64'(approx_cnt), 64'd0);
    check("clr_xfer_done", 64'(out_valid), 64'd0);

    // Mid-flight reset with two results in the pipe
    out_ready = 1'b0;
    in_a      = 23'd11;
    in_b      = 23'd13;
    in_valid  = 1'b1;
    tick();
    in_a = 23'd17;
    tick();
    in_valid = 1'b0;
    tick();
    check("inflight_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_p", 64'(out_p), 64'd0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("no_stale_after_rst", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
